imem_param: RTL and testbench

Parameterised instruction memory for the single-cycle/multicycle core, and the successor to the fixed 16x32 instruction store. It serves a fetch port with one-cycle registered read latency and a program-load port with a valid/ready handshake and auto-incrementing addresses. On reset, a sequencer sweeps every word to a fill value before it accepts any traffic. It sits between the PC/fetch stage and the boot or testbench program loader.

---
 rtl/imem_param.sv | 173 +++++++++++++++++
 tb/tb_imem_param.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_param.sv
// imem_param: parameterised instruction memory.
//
// After reset, an internal sequencer writes FILL to every word (INIT). It then
// serves fetches and program loads (RUN).
//
// Fetch port:
//   - fetch_req / fetch_addr in.
//   - fetch_rdata / fetch_valid / fetch_err out, registered with one-cycle latency.
//   - A misaligned or out-of-range byte address returns fetch_err=1 and fetch_rdata=0.
//
// Load port:
//   - load_valid / load_ready handshake.
//   - load_first starts a burst at load_addr. Later beats auto-increment and wrap.
//   - words_loaded counts beats since the last load_first and saturates at DEPTH.
//
// Status:
//   - busy: high while the reset sweep runs.
//
// Clock and reset:
//   - clk: all state updates on the rising edge.
//   - reset: synchronous, active-high.
module imem_param #(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 16,
  parameter int               AW    = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] FILL  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_req,
  input  logic [31:0]      fetch_addr,
  output logic [WIDTH-1:0] fetch_rdata,
  output logic             fetch_valid,
  output logic             fetch_err,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             load_first,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  output logic             busy,
  output logic [AW:0]      words_loaded
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [AW-1:0] SWEEP_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   WL_ONE     = (AW + 1)'(1);
  localparam logic [AW:0]   WL_MAX     = (AW + 1)'(DEPTH);

  state_e           state_q, state_d;
  logic [AW-1:0]    sweep_q, sweep_d;
  logic [AW-1:0]    lptr_q, lptr_d;
  logic [AW:0]      wl_q, wl_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             fvalid_q, fvalid_d;
  logic             ferr_q, ferr_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  logic [AW-1:0]    fetch_idx;
  logic             fetch_bad;

  assign fetch_idx = fetch_addr[AW+1:2];
  // Any set bit above the array, or a non-word-aligned address, is an error.
  assign fetch_bad = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:AW+2] != '0);

  // Status outputs are plain decodes of the state register.
  assign busy         = (state_q == ST_INIT);
  assign load_ready   = (state_q == ST_RUN);
  assign fetch_rdata  = rdata_q;
  assign fetch_valid  = fvalid_q;
  assign fetch_err    = ferr_q;
  assign words_loaded = wl_q;

  // Next-state logic: the sweep sequencer, fetch response and load bookkeeping.
  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    lptr_d   = lptr_q;
    wl_d     = wl_q;
    rdata_d  = rdata_q;
    fvalid_d = 1'b0;
    ferr_d   = ferr_q;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    case (state_q)
      ST_INIT: begin
        wr_en   = 1'b1;
        wr_addr = sweep_q;
        wr_data = FILL;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == SWEEP_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        // The read uses the array before this cycle's write lands, so a
        // colliding load is seen only by the next fetch.
        if (fetch_req) begin
          fvalid_d = 1'b1;
          if (fetch_bad) begin
            rdata_d = '0;
            ferr_d  = 1'b1;
          end else begin
            rdata_d = mem_q[fetch_idx];
            ferr_d  = 1'b0;
          end
        end else begin
          fvalid_d = 1'b0;
        end
        if (load_valid) begin
          wr_en   = 1'b1;
          wr_addr = load_first ? load_addr : lptr_q;
          wr_data = load_data;
          lptr_d  = wr_addr + 1'b1;
          if (load_first) begin
            wl_d = WL_ONE;
          end else if (wl_q != WL_MAX) begin
            wl_d = wl_q + 1'b1;
          end else begin
            wl_d = wl_q;
          end
        end else begin
          wr_en = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // Control and fetch-output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_INIT;
      sweep_q  <= '0;
      lptr_q   <= '0;
      wl_q     <= '0;
      rdata_q  <= '0;
      fvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      lptr_q   <= lptr_d;
      wl_q     <= wl_d;
      rdata_q  <= rdata_d;
      fvalid_q <= fvalid_d;
      ferr_q   <= ferr_d;
    end
  end

  // Storage array. It is not reset directly: the sweep refills it, and a beat
  // presented together with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_imem_param.sv
// Self-checking bench for imem_param.
//
// Two configurations run side by side:
//   - WIDTH=32, DEPTH=16, FILL=DEADBEEF.
//   - WIDTH=16, DEPTH=64, FILL=A5C3.
//
// Each configuration keeps its own behavioural model: an array of words plus
// sweep/pointer/count integers. Every cycle, all outputs are compared against
// that model. A set of hand-computed literal checks pins the model itself.
module tb_imem_param;

  logic clk;
  int   n_total;
  int   n_pass;
  int   done_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int cfg, input logic [31:0] act,
                     input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL cfg%0d %s: got %h, expected %h", cfg, nm, act, exp_v);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int          W     = (g == 0) ? 32 : 16;
    localparam int          DEP   = (g == 0) ? 16 : 64;
    localparam int          A     = $clog2(DEP);
    localparam logic [31:0] F32   = (g == 0) ? 32'hDEAD_BEEF : 32'h0000_A5C3;
    localparam logic [W-1:0] FILLV = F32[W-1:0];

    logic          reset, fetch_req, fetch_valid, fetch_err;
    logic          load_valid, load_ready, load_first, busy;
    logic [31:0]   fetch_addr;
    logic [W-1:0]  fetch_rdata, load_data;
    logic [A-1:0]  load_addr;
    logic [A:0]    words_loaded;

    imem_param #(.WIDTH(W), .DEPTH(DEP), .FILL(FILLV)) u_dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_rdata(fetch_rdata), .fetch_valid(fetch_valid), .fetch_err(fetch_err),
      .load_valid(load_valid), .load_ready(load_ready), .load_first(load_first),
      .load_addr(load_addr), .load_data(load_data),
      .busy(busy), .words_loaded(words_loaded)
    );

    // Model state.
    logic [W-1:0] m_mem [DEP];
    int           m_sweep_left;
    int           m_lptr;
    int           m_wl;
    logic         m_fv;
    logic         m_fe;
    logic         m_fe_known;
    logic [W-1:0] m_rd;

    task automatic model_edge();
      int wa;
      if (reset) begin
        m_sweep_left = DEP;
        m_lptr = 0;
        m_wl = 0;
        m_fv = 1'b0;
        m_fe = 1'b0;
        m_fe_known = 1'b1;
        m_rd = '0;
        for (int i = 0; i < DEP; i++) m_mem[i] = FILLV;
      end else if (m_sweep_left > 0) begin
        m_sweep_left--;
        m_fv = 1'b0;
      end else begin
        m_fv = fetch_req;
        m_fe_known = fetch_req;
        if (fetch_req) begin
          if ((fetch_addr % 4) != 0 || fetch_addr >= 32'(DEP * 4)) begin
            m_fe = 1'b1;
            m_rd = '0;
          end else begin
            m_fe = 1'b0;
            m_rd = m_mem[int'(fetch_addr >> 2)];
          end
        end
        if (load_valid) begin
          wa = load_first ? int'(load_addr) : m_lptr;
          m_mem[wa] = load_data;
          m_lptr = (wa + 1) % DEP;
          m_wl = load_first ? 1 : ((m_wl < DEP) ? m_wl + 1 : DEP);
        end
      end
    endtask

    task automatic compare();
      chk("fetch_valid", g, 32'(fetch_valid), 32'(m_fv));
      chk("busy", g, 32'(busy), 32'(m_sweep_left > 0));
      chk("load_ready", g, 32'(load_ready), 32'(m_sweep_left == 0));
      chk("words_loaded", g, 32'(words_loaded), 32'(m_wl));
      chk("fetch_rdata", g, 32'(fetch_rdata), 32'(m_rd));
      if (m_fe_known) chk("fetch_err", g, 32'(fetch_err), 32'(m_fe));
    endtask

    task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
    endtask

    task automatic idle();
      fetch_req = 1'b0;
      fetch_addr = 32'h0;
      load_valid = 1'b0;
      load_first = 1'b0;
      load_addr = '0;
      load_data = '0;
    endtask

    task automatic fetch_at(input logic [31:0] addr);
      idle();
      fetch_req = 1'b1;
      fetch_addr = addr;
      step();
      idle();
    endtask

    initial begin
      idle();
      reset = 1'b1;
      step();
      step();
      chk("reset_busy", g, 32'(busy), 32'd1);
      chk("reset_words_loaded", g, 32'(words_loaded), 32'd0);
      chk("reset_rdata", g, 32'(fetch_rdata), 32'd0);

      // Sweep, with fetches and loads presented that must be ignored.
      reset = 1'b0;
      fetch_req = 1'b1;
      load_valid = 1'b1;
      load_first = 1'b1;
      load_data = '1;
      for (int i = 1; i <= DEP; i++) begin
        step();
        if (i == DEP - 1) chk("busy_last_sweep", g, 32'(busy), 32'd1);
      end
      chk("busy_after_sweep", g, 32'(busy), 32'd0);
      chk("ready_after_sweep", g, 32'(load_ready), 32'd1);
      idle();
      fetch_at(32'((DEP - 1) * 4));
      chk("fill_top_word", g, 32'(fetch_rdata), F32);
      chk("fill_top_valid", g, 32'(fetch_valid), 32'd1);

      // Wrapping burst from DEP-2, data k+1, then one saturating beat.
      for (int k = 0; k < DEP; k++) begin
        load_valid = 1'b1;
        load_first = (k == 0);
        load_addr = A'(DEP - 2);
        load_data = W'(k + 1);
        step();
        chk("wl_burst", g, 32'(words_loaded), 32'(k + 1));
      end
      load_first = 1'b0;
      load_data = W'(DEP + 1);
      step();
      chk("wl_saturate", g, 32'(words_loaded), 32'(DEP));
      fetch_at(32'h0);
      chk("word0_after_wrap", g, 32'(fetch_rdata), 32'd3);

      // Error fetches, then a good fetch.
      fetch_at(32'h2);
      chk("misaligned_err", g, 32'(fetch_err), 32'd1);
      chk("misaligned_rdata", g, 32'(fetch_rdata), 32'd0);
      fetch_at(32'(DEP * 4));
      chk("range_err", g, 32'(fetch_err), 32'd1);
      chk("range_valid", g, 32'(fetch_valid), 32'd1);
      fetch_at(32'h4);
      chk("good_err", g, 32'(fetch_err), 32'd0);
      chk("good_rdata", g, 32'(fetch_rdata), 32'd4);

      // Same-cycle load and fetch of word 5.
      load_valid = 1'b1;
      load_first = 1'b1;
      load_addr = A'(5);
      load_data = W'(32'h1234);
      fetch_req = 1'b1;
      fetch_addr = 32'h14;
      step();
      chk("collide_old", g, 32'(fetch_rdata), 32'd8);
      fetch_at(32'h14);
      chk("collide_new", g, 32'(fetch_rdata), 32'h1234);

      // Reset on beat 3 of a burst, with a fetch response pending.
      load_valid = 1'b1;
      load_first = 1'b1;
      load_addr = '0;
      load_data = W'(32'h100);
      step();
      load_first = 1'b0;
      load_data = W'(32'h101);
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      load_data = W'(32'h102);
      reset = 1'b1;
      step();
      chk("midburst_busy", g, 32'(busy), 32'd1);
      chk("midburst_fv_cleared", g, 32'(fetch_valid), 32'd0);
      reset = 1'b0;
      idle();
      for (int i = 0; i < 7; i++) step();
      chk("midsweep_busy", g, 32'(busy), 32'd1);

      // Reset at sweep word 7: the full sweep must run again.
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 1; i <= DEP; i++) begin
        step();
        if (i == DEP - 1) chk("resweep_busy_last", g, 32'(busy), 32'd1);
        if (i == DEP) chk("resweep_busy_done", g, 32'(busy), 32'd0);
      end

      // Back-to-back fetches of every word; everything must read FILL again.
      for (int i = 0; i < DEP; i++) begin
        fetch_req = 1'b1;
        fetch_addr = 32'(i * 4);
        step();
        if (i == 2) chk("dropped_beat_fill", g, 32'(fetch_rdata), F32);
      end
      idle();
      step();
      done_cnt++;
    end
  end

  initial begin
    int guard;
    n_total = 0;
    n_pass = 0;
    done_cnt = 0;
    guard = 0;
    while (done_cnt < 2 && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    if (done_cnt < 2) begin
      n_total++;
      $display("FAIL timeout: done %0d, expected 2", done_cnt);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
